instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage of the single-issue CPU. Sits directly upstream of instruction_memory.
//  Holds the PC and drives it as the memory Addr. Latches the combinational read data
//  into an instruction register for decode.
//  Applies stall and branch/jump/jr redirects; no delay slot: the wrong-path fetch is squashed.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (byte address, must be 4-aligned)
//  PC_STEP   4              sequential PC increment in bytes
// PORTS
//  clk            in   1   single clock; all state updates on posedge
//  reset          in   1   asynchronous, active-high reset
//  imem_addr      out  32  byte address to instruction_memory Addr; equals PC register
//  imem_regWE     out  1   instruction_memory write enable; constant 0
//  imem_rdata     in   32  instruction_memory DataOut (combinational read of imem_addr)
//  stall          in   1   decode not accepting; hold all fetch state
//  branch_taken   in   1   decode resolves taken branch for instr in if_instr
//  branch_offset  in   32  sign-extended 16-bit word offset
//  jump           in   1   j/jal in decode
//  jump_target    in   26  j-format target field
//  jr             in   1   jr in decode
//  jr_addr        in   32  register value for jr
//  if_valid       out  1   if_instr/if_pc hold a real instruction
//  if_instr       out  32  instruction register
//  if_pc          out  32  byte address of if_instr
//  if_pc_plus4    out  32  if_pc + PC_STEP (mod 2^32), link value for jal
//  misalign_err   out  1   sticky: jr_addr had nonzero bits [1:0]
//  fetch_count    out  32  number of instructions delivered with if_valid=1 (wraps)
// BEHAVIOUR
//  Reset (async, immediate on reset=1, any cycle incl. mid-redirect):
//  - PC=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
//  - misalign_err=0, fetch_count=0, state=BOOT.
//  FSM states:
//  - BOOT: first edge after reset release. IR<=imem_rdata, if_pc<=PC, if_valid<=1.
//    PC<=PC+PC_STEP. Go to RUN. stall is ignored in BOOT.
//  - RUN, stall=1: PC, IR, if_pc, if_valid, fetch_count all hold. Redirect inputs ignored.
//  - RUN, stall=0, no redirect: IR<=imem_rdata, if_pc<=PC, if_valid<=1, PC<=PC+PC_STEP.
//  - RUN, stall=0, if_valid=1, redirect: PC<=target, if_valid<=0 (squash in-flight fetch).
//    Go to FLUSH.
//  - FLUSH: behaves as RUN/no-redirect: loads target instruction, if_valid<=1, returns to RUN.
//    Redirects in FLUSH are ignored (if_valid=0). stall in FLUSH holds state in FLUSH.
//  Redirect rules:
//  - Redirect inputs are honoured only when if_valid=1 and stall=0.
//  - Priority is jr > jump > branch_taken.
//  - Branch target = if_pc_plus4 + (branch_offset<<2).
//  - Jump target = {if_pc_plus4[31:28], jump_target, 2'b00}.
//  - jr target = {jr_addr[31:2], 2'b00}; if jr_addr[1:0]!=0, set misalign_err (sticky until reset).
//  Arithmetic and counters:
//  - All address arithmetic is 32-bit modulo 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0.
//  - fetch_count increments on every edge where if_valid goes/stays 1 with a newly loaded IR.
//    It does not increment on stall holds; it wraps 32'hFFFF_FFFF->0.
//  Latency: a redirect costs exactly 1 bubble cycle. Sequential fetch delivers 1 instr/cycle.
// TESTING
//  1. Reset with RESET_PC=0, mem[0]=A, mem[4]=B, mem[8]=C, no stall.
//     Expect if_instr A,B,C on cycles 1,2,3 after release; if_pc 0,4,8; fetch_count=3.
//  2. stall=1 for 3 cycles while if_pc=4.
//     Expect if_instr/if_pc/imem_addr frozen; fetch_count unchanged; resumes at 8.
//  3. branch_taken=1, branch_offset=-2 at if_pc=8.
//     Expect one if_valid=0 cycle, then if_pc=4.
//     Also assert jump and jr in the same cycle: jr wins.
//  4. jump with jump_target=26'h10 at if_pc=32'h1000_0000.
//     Expect next valid if_pc=32'h1000_0040.
//  5. jr_addr=32'h0000_0013.
//     Expect PC=0x10, misalign_err=1 held until reset. Separately, PC=FFFF_FFFC: next PC=0.
//  6. Assert reset during FLUSH.
//     Expect outputs cleared in the same cycle, no posedge needed; BOOT replays from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory, registers the fetched word for decode.
// A taken redirect squashes the in-flight fetch and costs one bubble before the target arrives.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_regWE,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        misalign_err,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_if_pc;
  logic        r_valid;
  logic        r_misalign;
  logic [31:0] r_count;

  logic        w_redir_req;
  logic        w_load;
  logic        w_redirect;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_pc_plus4  = r_if_pc + STEP;
  assign w_redir_req = jr | jump | branch_taken;

  // jr wins over jump, jump wins over a taken branch.
  always_comb begin
    w_target = w_pc_plus4 + (branch_offset << 2);
    if (jr)
      w_target = {jr_addr[31:2], 2'b00};
    else if (jump)
      w_target = {w_pc_plus4[31:28], jump_target, 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_BOOT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT:  w_next_state = S_RUN;
      S_RUN:   if (!stall && r_valid && w_redir_req) w_next_state = S_FLUSH;
      S_FLUSH: if (!stall) w_next_state = S_RUN;
      default: w_next_state = S_BOOT;
    endcase
  end

  // BOOT ignores stall; in FLUSH r_valid is 0 so redirect requests fall through to a load.
  always_comb begin
    w_load     = 1'b0;
    w_redirect = 1'b0;
    case (r_state)
      S_BOOT:  w_load = 1'b1;
      S_RUN: begin
        w_redirect = !stall && r_valid && w_redir_req;
        w_load     = !stall && !(r_valid && w_redir_req);
      end
      S_FLUSH: w_load = !stall;
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0;
      r_if_pc    <= 32'h0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_count    <= 32'h0;
    end else if (w_load) begin
      r_ir    <= imem_rdata;
      r_if_pc <= r_pc;
      r_valid <= 1'b1;
      r_pc    <= r_pc + STEP;
      r_count <= r_count + 32'd1;
    end else if (w_redirect) begin
      r_pc    <= w_target;
      r_valid <= 1'b0;
      if (jr && (jr_addr[1:0] != 2'b00)) r_misalign <= 1'b1;
    end
  end

  assign imem_addr    = r_pc;
  assign imem_regWE   = 1'b0;
  assign if_valid     = r_valid;
  assign if_instr     = r_ir;
  assign if_pc        = r_if_pc;
  assign if_pc_plus4  = w_pc_plus4;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random stall/redirect/reset traffic,
// every cycle compared against a reference model of the fetch rules.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_regWE;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;
  logic        jr = 1'b0;
  logic [31:0] jr_addr = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [31:0] m_pc, m_instr, m_ifpc, m_count;
  logic        m_valid, m_mis, m_boot;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_regWE(imem_regWE), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .misalign_err(misalign_err), .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0; m_count = 32'h0;
    m_valid = 1'b0; m_mis = 1'b0; m_boot = 1'b1;
  endtask

  // Fetch rules applied to the inputs present at a clock edge.
  task automatic model_step();
    logic [31:0] nxt;
    if (m_boot || (!stall && !(m_valid && (jr || jump || branch_taken)))) begin
      m_boot  = 1'b0;
      m_instr = mem_f(m_pc);
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_count = m_count + 32'd1;
    end else if (!stall) begin
      nxt = m_ifpc + 32'd4;
      if (jr) begin
        m_pc = jr_addr & 32'hFFFF_FFFC;
        if (jr_addr[1:0] != 2'b00) m_mis = 1'b1;
      end else if (jump) m_pc = {nxt[31:28], jump_target, 2'b00};
      else m_pc = nxt + branch_offset * 32'd4;
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  imem_addr, m_pc);
    check({tag, ".we"},    {31'h0, imem_regWE}, 32'h0);
    check({tag, ".valid"}, {31'h0, if_valid}, {31'h0, m_valid});
    check({tag, ".instr"}, if_instr, m_instr);
    check({tag, ".pc"},    if_pc, m_ifpc);
    check({tag, ".pc4"},   if_pc_plus4, m_ifpc + 32'd4);
    check({tag, ".mis"},   {31'h0, misalign_err}, {31'h0, m_mis});
    check({tag, ".cnt"},   fetch_count, m_count);
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] off,
                       input logic j, input logic [25:0] jt, input logic r, input logic [31:0] ra);
    stall = s; branch_taken = b; branch_offset = off;
    jump = j; jump_target = jt; jr = r; jr_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Reset is raised between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    reset = 1'b0;
  endtask

  initial begin
    idle();
    #2;
    do_reset();

    // Sequential boot: A, B, C at 0, 4, 8
    tick("seq1"); check("seq1.instrA", if_instr, mem_f(32'h0));
    tick("seq2"); check("seq2.pc", if_pc, 32'h4);
    tick("seq3"); check("seq3.instrC", if_instr, mem_f(32'h8));
    check("seq3.count", fetch_count, 32'd3);

    // Stall while if_pc = 4
    do_reset();
    tick("s1"); tick("s2");
    drive(1'b1, 1'b1, 32'h10, 1'b0, 26'h0, 1'b1, 32'h44);
    for (int i = 0; i < 3; i++) tick("stall");
    check("stall.pc", if_pc, 32'h4);
    check("stall.addr", imem_addr, 32'h8);
    check("stall.cnt", fetch_count, 32'd2);
    idle();
    tick("resume"); check("resume.pc", if_pc, 32'h8);

    // Branch -2 at if_pc=8 -> bubble, then 4
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0);
    tick("br_bubble"); check("br_bubble.valid", {31'h0, if_valid}, 32'h0);
    idle();
    tick("br_tgt"); check("br_tgt.pc", if_pc, 32'h4);

    // All three redirects: jr wins
    drive(1'b0, 1'b1, 32'h8, 1'b1, 26'h3F, 1'b1, 32'h1000_0000);
    tick("prio_bubble");
    idle();
    tick("prio_tgt"); check("prio_tgt.pc", if_pc, 32'h1000_0000);

    // Jump at if_pc=1000_0000, target field 0x10
    drive(1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 1'b0, 32'h0);
    tick("j_bubble");
    idle();
    tick("j_tgt"); check("j_tgt.pc", if_pc, 32'h1000_0040);

    // Misaligned jr, sticky flag
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0013);
    tick("jr_bubble"); check("jr_bubble.addr", imem_addr, 32'h10);
    idle();
    tick("jr_tgt"); check("jr_tgt.mis", {31'h0, misalign_err}, 32'h1);
    tick("jr_sticky"); check("jr_sticky.mis", {31'h0, misalign_err}, 32'h1);

    // PC wrap at FFFF_FFFC
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
    tick("wrap_bubble");
    idle();
    tick("wrap_tgt"); check("wrap.pc", if_pc, 32'hFFFF_FFFC);
    check("wrap.addr", imem_addr, 32'h0);
    tick("wrap_next"); check("wrap_next.pc", if_pc, 32'h0);

    // Reset during FLUSH, then BOOT replays from 0
    drive(1'b0, 1'b0, 32'h0, 1'b1, 26'h123, 1'b0, 32'h0);
    tick("fl_bubble"); check("fl.valid", {31'h0, if_valid}, 32'h0);
    idle();
    do_reset();
    tick("reboot"); check("reboot.pc", if_pc, 32'h0);
    check("reboot.instr", if_instr, mem_f(32'h0));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
            32'($urandom_range(0, 511)) - 32'd256,
            $urandom_range(0, 9) == 0, 26'($urandom),
            $urandom_range(0, 11) == 0, ra);
      if ($urandom_range(0, 399) == 0) begin
        idle();
        do_reset();
      end else begin
        tick("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
